// File: rtl/seq_alu_core_if.sv
// Request/response handshake bundle between the EX-stage operand source and seq_alu_core.
// The master drives requests and consumes results; the slave is the ALU core.
interface seq_alu_core_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALU_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, ALU_sel, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, illegal
  );

  modport slave (
    input  in_valid, ALU_sel, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, illegal
  );
endinterface

// File: rtl/seq_alu_core.sv
// Handshaked EX-stage ALU: one-cycle logic/arith/compare, iterative 1-bit/cycle shifts.
// Define SEQ_ALU_FAST_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shifter.
module seq_alu_core #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  seq_alu_core_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_SLL = 4'b1000,
    OP_SRL = 4'b1001,
    OP_SRA = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifndef SEQ_ALU_FAST_SHIFT_EN
    S_SHIFT = 2'd1,
`endif
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             overflow_q;
  logic             illegal_q;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;

  assign shamt = bus.op_b[SHW-1:0];

`ifndef SEQ_ALU_FAST_SHIFT_EN
  logic             is_shift;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_step;
  logic [SHW-1:0]   cnt_q;
  logic [1:0]       sh_sel_q;
`endif

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
    is_shift = 1'b0;
`endif
    case (bus.ALU_sel)
      OP_AND: alu_res = bus.op_a & bus.op_b;
      OP_OR:  alu_res = bus.op_a | bus.op_b;
      OP_XOR: alu_res = bus.op_a ^ bus.op_b;
      OP_ADD: begin
        sum     = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry-out of a + ~b + 1 is "no borrow", so it is inverted.
        sum     = {1'b0, bus.op_a} + {1'b0, ~bus.op_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[WIDTH-1:0];
        alu_c   = ~sum[WIDTH];
        alu_v   = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
`ifdef SEQ_ALU_FAST_SHIFT_EN
      OP_SLL: alu_res = bus.op_a << shamt;
      OP_SRL: alu_res = bus.op_a >> shamt;
      OP_SRA: alu_res = $signed(bus.op_a) >>> shamt;
`else
      OP_SLL, OP_SRL, OP_SRA: begin
        is_shift = 1'b1;
        alu_res  = bus.op_a;
      end
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifndef SEQ_ALU_FAST_SHIFT_EN
  always_comb begin
    work_step = work_q;
    case (sh_sel_q)
      2'b00:   work_step = {work_q[WIDTH-2:0], 1'b0};
      2'b01:   work_step = {1'b0, work_q[WIDTH-1:1]};
      default: work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
      work_q      <= '0;
      cnt_q       <= '0;
      sh_sel_q    <= 2'b00;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
            if (is_shift && (shamt != '0)) begin
              work_q   <= bus.op_a;
              cnt_q    <= shamt;
              sh_sel_q <= bus.ALU_sel[1:0];
              state_q  <= S_SHIFT;
            end else
`endif
            begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              carry_q     <= alu_c;
              overflow_q  <= alu_v;
              illegal_q   <= alu_ill;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
`ifndef SEQ_ALU_FAST_SHIFT_EN
        S_SHIFT: begin
          work_q <= work_step;
          cnt_q  <= cnt_q - 1'b1;
          // The final step publishes straight to the result, so the counter stops at zero.
          if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
            result_q    <= work_step;
            zero_q      <= (work_step == '0);
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_seq_alu_core.sv
// Directed plus randomized bench for seq_alu_core against an arithmetic reference model.
module tb_seq_alu_core;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_alu_core_if #(.WIDTH(WIDTH)) bus ();
  seq_alu_core #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        ill;
    int          lat;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: flags from wide signed/unsigned arithmetic, latency from the shift amount.
  function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    longint sa, sb, sr;
    longint unsigned u;
    logic [4:0] bn;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    bn = b[4:0];
    n  = int'(bn);
    m.res = 32'h0; m.c = 1'b0; m.v = 1'b0; m.ill = 1'b0; m.lat = 0;
    case (sel)
      4'b0000: m.res = a & b;
      4'b0001: m.res = a | b;
      4'b0011: m.res = a ^ b;
      4'b0010: begin
        u = longint'(a) + longint'(b);
        m.res = u[31:0];
        m.c = u[32];
        sr = sa + sb;
        m.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'b0110: begin
        m.res = a - b;
        m.c = (a < b);
        sr = sa - sb;
        m.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'b0111: m.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: begin m.res = a << n; m.lat = n; end
      4'b1001: begin m.res = a >> n; m.lat = n; end
      4'b1010: begin m.res = $signed(a) >>> n; m.lat = n; end
      default: m.ill = 1'b1;
    endcase
`ifdef SEQ_ALU_FAST_SHIFT_EN
    m.lat = 0;
`endif
    m.z = (m.res == 32'h0);
    return m;
  endfunction

  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit noise);
    exp_t e;
    int   w;
    int   lat;
    bit   busy_ok;
    e = model(sel, a, b);
    w = 0;
    while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.ALU_sel   = sel;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // Held or changing request while busy must not be re-captured.
    bus.in_valid = noise;
    if (noise) begin
      bus.ALU_sel = 4'($urandom);
      bus.op_a    = $urandom;
      bus.op_b    = $urandom;
    end
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, e.lat);
    check("busy_no_ready", busy_ok, 1);
    check("out_valid", bus.out_valid, 1);
    check("in_ready_done", bus.in_ready, 0);
    check("result", bus.result, e.res);
    check("zero", bus.zero, e.z);
    check("carry", bus.carry, e.c);
    check("overflow", bus.overflow, e.v);
    check("illegal", bus.illegal, e.ill);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_result", bus.result, e.res);
      check("hold_flags", {bus.zero, bus.carry, bus.overflow, bus.illegal}, {e.z, e.c, e.v, e.ill});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("post_hs_valid", bus.out_valid, 0);
    check("post_hs_ready", bus.in_ready, 1);
  endtask

  initial begin
    int seen_valid;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.ALU_sel = 4'h0; bus.op_a = '0; bus.op_b = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_flags", {bus.zero, bus.carry, bus.overflow, bus.illegal}, 4'b0000);
    rst = 1'b0;

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 1'b0);
    run_op(4'b0110, 32'd5, 32'd5, 0, 1'b0);
    run_op(4'b0110, 32'd3, 32'd5, 0, 1'b0);
    run_op(4'b1010, 32'h8000_0000, 32'd4, 0, 1'b0);
    run_op(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 0, 1'b0);
    run_op(4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 0, 1'b0);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h0, 0, 1'b0);
    run_op(4'b0011, 32'hA5A5_A5A5, 32'hFFFF_0000, 3, 1'b1);
    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 3, 1'b1);
    run_op(4'b1000, 32'h0000_0003, 32'hFFFF_FFFF, 1, 1'b0);
    run_op(4'b1001, 32'h8000_0001, 32'h0000_0040, 0, 1'b0);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);
    run_op(4'b0110, 32'h8000_0000, 32'h1, 0, 1'b0);

    // Reset two cycles into a long shift discards the operation.
    bus.in_valid = 1'b1; bus.ALU_sel = 4'b1000; bus.op_a = 32'h1; bus.op_b = 32'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_result", bus.result, 0);
    check("midrst_flags", {bus.zero, bus.carry, bus.overflow, bus.illegal}, 4'b0000);
    seen_valid = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_valid++;
    end
    check("midrst_no_result", seen_valid, 0);

    for (int k = 0; k < 40; k++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_alu_core.md
Name: seq_alu_core

Overview:
- Execution-side consumer of the 4-bit ALU select code driven by the ALU control unit; sits in the EX stage between the register-read operands and the write-back mux.
- Accepts one operation per valid/ready handshake and returns the result plus flags on an output valid/ready handshake.
- Logic ops, arithmetic and compare complete in one cycle. Shifts are iterative, one bit per cycle, unless the fast-shift option is compiled in.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >= 8)
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operation request
- in_ready  output  1  core can accept a request
- ALU_sel  input  4  operation select
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B; shift amount = op_b[SHW-1:0]
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- carry  output  1  ADD carry-out; SUB borrow (op_a < op_b unsigned); else 0
- overflow  output  1  signed overflow for ADD/SUB; else 0
- illegal  output  1  ALU_sel not in the supported set

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Select encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (shared with the ALU control unit)
  - 0011 XOR, 0111 SLT (signed, result 1 or 0), 1000 SLL, 1001 SRL, 1010 SRA
  - All other codes are illegal: result=0, zero=1, carry=0, overflow=0, illegal=1, with single-cycle latency.
- States: IDLE, SHIFT, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, carry=0, overflow=0, illegal=0, shift counter=0.
- in_ready = (state==IDLE). The core holds one operation at a time, with no overlap.
- Accept: on a cycle T with in_valid && in_ready, ALU_sel and operands are captured. Inputs are ignored at all other times.
- Non-shift op, or shift with amount 0: result and flags are registered at edge T, and state goes IDLE->DONE. out_valid=1 from cycle T+1.
- Shift with amount n>0:
  - Edge T loads the working register with op_a and the counter with n; IDLE->SHIFT.
  - Each SHIFT cycle shifts by 1 (SLL fills 0, SRL fills 0, SRA fills the sign bit) and decrements the counter.
  - After the counter reaches 0, the state goes SHIFT->DONE. out_valid=1 from cycle T+1+n.
- DONE: result and flags stay stable while out_valid=1 && !out_ready. When out_valid && out_ready, the state goes DONE->IDLE and out_valid=0 on the next cycle.
- A new request is accepted no earlier than the cycle after the result handshake. No back-to-back bypass.
- Arithmetic rules:
  - ADD/SUB use a WIDTH+1-bit sum; carry is bit WIDTH (for SUB, inverted into a borrow).
  - overflow = operand signs equal (ADD) or different (SUB), and result sign differs from op_a.
  - Results wrap modulo 2^WIDTH.
- zero is computed from the final result for every op.
- Boundary cases:
  - Shift amount WIDTH-1 takes WIDTH-1 SHIFT cycles. The counter never underflows.
  - Upper bits of op_b beyond SHW are ignored for shifts.
  - rst asserted in any state, including mid-SHIFT or DONE with a pending result, returns all outputs to reset values on the next edge. The in-flight operation is discarded and no out_valid is produced for it.
  - in_valid held high while busy has no effect and causes no re-capture.

Optional Feature:
- Macro SEQ_ALU_FAST_SHIFT_EN.
- Defined: SLL/SRL/SRA use a combinational barrel shifter and complete in one cycle like the other ops. The SHIFT state and counter are not built.
- Undefined: iterative 1-bit/cycle shifter as described above.
- Results and flags are identical in both builds; only latency differs.

Test Plan:
- Reset, then ALU_sel=0010, a=0x7FFFFFFF, b=1, out_ready=1 -> out_valid at T+1; result=0x80000000, overflow=1, carry=0, zero=0.
- ALU_sel=0110, a=5, b=5 -> result=0, zero=1, carry=0; then a=3, b=5 -> result=0xFFFFFFFE, carry=1.
- ALU_sel=1010 (SRA), a=0x80000000, b=4 -> out_valid at T+5 (T+1 with SEQ_ALU_FAST_SHIFT_EN); result=0xF8000000; in_ready=0 throughout.
- ALU_sel=0000/0001/0111 with a=0xF0F0, b=0x0FF0 / a=-1, b=0 -> AND=0x00F0, OR=0xFFF0, SLT=1.
- Backpressure: out_ready=0 for 3 cycles after out_valid -> result/flags stable, in_ready=0; then out_ready=1 -> idle next cycle. Also ALU_sel=1111 -> illegal=1, result=0, zero=1.
- rst asserted 2 cycles into SLL with b=20 -> next cycle out_valid=0, in_ready=1; no result emitted for that op.
